// File: rtl/text_glyph_fetch.sv
// Text-mode glyph fetch: character buffer, font ROM addressing, 3-cycle pixel pipeline.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
`timescale 1ns/1ps
module text_glyph_fetch #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic        i_pixel_clk,
  input  logic        i_rst,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [6:0]  i_wr_col,
  input  logic [4:0]  i_wr_row,
  input  logic [7:0]  i_wr_char,
  output logic        o_wr_err,
  input  logic        i_clr_req,
  input  logic [9:0]  i_pix_x,
  input  logic [9:0]  i_pix_y,
  input  logic        i_pix_active,
`ifdef CURSOR_BLINK_EN
  input  logic [6:0]  i_cursor_col,
  input  logic [4:0]  i_cursor_row,
`endif
  output logic [11:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  output logic        o_pix_on,
  output logic        o_pix_de
);

  localparam int unsigned DEPTH  = COLS * ROWS;
  localparam logic [11:0] COLS_W = 12'(COLS);
  localparam logic [11:0] ROWS_W = 12'(ROWS);
  localparam logic [11:0] LAST_W = 12'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]  r_state;
  logic [11:0] r_clr_addr;
  logic        r_wr_err;
  logic [7:0]  r_mem [DEPTH];

  logic        w_idle;
  logic        w_wr_fire;
  logic        w_wr_in_range;
  logic [11:0] w_wr_idx;
  logic        w_mem_we;
  logic [11:0] w_mem_waddr;
  logic [7:0]  w_mem_wdata;
  logic [11:0] w_rd_idx;

  always_comb begin
    w_idle        = (r_state == ST_IDLE);
    w_wr_fire     = w_idle & i_wr_valid;
    w_wr_in_range = ({5'd0, i_wr_col} < COLS_W) && ({7'd0, i_wr_row} < ROWS_W);
    w_wr_idx      = 12'(i_wr_row) * COLS_W + 12'(i_wr_col);
    w_rd_idx      = 12'(i_pix_y[9:4]) * COLS_W + 12'(i_pix_x[9:3]);
    // The clear sweep owns the write port; host writes only land in IDLE.
    if (w_idle) begin
      w_mem_we    = w_wr_fire & w_wr_in_range & ~i_rst;
      w_mem_waddr = w_wr_idx;
      w_mem_wdata = i_wr_char;
    end else begin
      w_mem_we    = ~i_rst;
      w_mem_waddr = r_clr_addr;
      w_mem_wdata = 8'h20;
    end
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= 12'd0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_err <= w_wr_fire & ~w_wr_in_range;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_addr == LAST_W) r_state <= ST_IDLE;
          else                      r_clr_addr <= r_clr_addr + 12'd1;
        end
        ST_IDLE: begin
          if (i_clr_req) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= 12'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_pixel_clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  // Pixel pipeline: S0 RAM read, S1 font fetch, S2 bit select.
  logic [7:0] r_ram_q;
  logic [3:0] r_y4;
  logic [2:0] r_x3_s1;
  logic       r_act_s1;
  logic [7:0] r_font_q;
  logic [2:0] r_x3_s2;
  logic       r_act_s2;
  logic       r_pix_on;
  logic       r_pix_de;
  logic       w_cur_inv;
  logic       w_bit;

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_ram_q  <= 8'd0;
      r_y4     <= 4'd0;
      r_x3_s1  <= 3'd0;
      r_act_s1 <= 1'b0;
      r_font_q <= 8'd0;
      r_x3_s2  <= 3'd0;
      r_act_s2 <= 1'b0;
      r_pix_on <= 1'b0;
      r_pix_de <= 1'b0;
    end else begin
      r_ram_q  <= r_mem[w_rd_idx];
      r_y4     <= i_pix_y[3:0];
      r_x3_s1  <= i_pix_x[2:0];
      r_act_s1 <= i_pix_active;
      r_font_q <= i_font_data;
      r_x3_s2  <= r_x3_s1;
      r_act_s2 <= r_act_s1;
      r_pix_on <= r_act_s2 & (w_bit ^ w_cur_inv);
      r_pix_de <= r_act_s2;
    end
  end

  assign w_bit = r_font_q[3'd7 - r_x3_s2];

`ifdef CURSOR_BLINK_EN
  logic [4:0] r_frame;
  logic       r_cur_s1;
  logic       r_cur_s2;
  logic       w_cur_hit;

  // Cursor occupies glyph rows 14..15 of its cell while the blink phase is high.
  assign w_cur_hit = r_frame[4] && (i_pix_x[9:3] == i_cursor_col) &&
                     (i_pix_y[9:4] == {1'b0, i_cursor_row}) && (i_pix_y[3:1] == 3'b111);

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_frame  <= 5'd0;
      r_cur_s1 <= 1'b0;
      r_cur_s2 <= 1'b0;
    end else begin
      if (i_pix_active && (i_pix_x == 10'd0) && (i_pix_y == 10'd0)) r_frame <= r_frame + 5'd1;
      r_cur_s1 <= w_cur_hit;
      r_cur_s2 <= r_cur_s1;
    end
  end

  assign w_cur_inv = r_cur_s2;
`else
  assign w_cur_inv = 1'b0;
`endif

  assign o_wr_ready  = w_idle;
  assign o_wr_err    = r_wr_err;
  assign o_font_addr = {r_ram_q, r_y4};
  assign o_pix_on    = r_pix_on;
  assign o_pix_de    = r_pix_de;

endmodule

// File: tb/tb_text_glyph_fetch.sv
// Directed self-checking bench for text_glyph_fetch; cursor scenario runs when CURSOR_BLINK_EN is defined.
`timescale 1ns/1ps
module tb_text_glyph_fetch;

  logic        clk = 1'b0;
  logic        rst, wr_valid, wr_ready, wr_err, clr_req;
  logic [6:0]  wr_col;
  logic [4:0]  wr_row;
  logic [7:0]  wr_char;
  logic [9:0]  pix_x, pix_y;
  logic        pix_active;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        pix_on, pix_de;
`ifdef CURSOR_BLINK_EN
  logic [6:0]  cursor_col = 7'd0;
  logic [4:0]  cursor_row = 5'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  text_glyph_fetch dut (
    .i_pixel_clk (clk),
    .i_rst       (rst),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_col    (wr_col),
    .i_wr_row    (wr_row),
    .i_wr_char   (wr_char),
    .o_wr_err    (wr_err),
    .i_clr_req   (clr_req),
    .i_pix_x     (pix_x),
    .i_pix_y     (pix_y),
    .i_pix_active(pix_active),
`ifdef CURSOR_BLINK_EN
    .i_cursor_col(cursor_col),
    .i_cursor_row(cursor_row),
`endif
    .o_font_addr (font_addr),
    .i_font_data (font_data),
    .o_pix_on    (pix_on),
    .o_pix_de    (pix_de)
  );

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int col, input int row, input logic [7:0] ch);
    wr_valid = 1'b1;
    wr_col   = 7'(col);
    wr_row   = 5'(row);
    wr_char  = ch;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_cell(input int col, input int row, output logic [7:0] code);
    pix_x      = 10'(col * 8);
    pix_y      = 10'(row * 16);
    pix_active = 1'b1;
    tick();
    code       = font_addr[11:4];
    pix_active = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic probe(input int x, input int y, input logic act, input logic [7:0] fd,
                       output logic [11:0] addr, output logic on, output logic de);
    pix_x      = 10'(x);
    pix_y      = 10'(y);
    pix_active = act;
    font_data  = fd;
    tick();
    addr       = font_addr;
    pix_active = 1'b0;
    tick();
    tick();
    on = pix_on;
    de = pix_de;
  endtask

  task automatic test_reset();
    int          n;
    logic [7:0]  code;
    int          cells [3][2] = '{'{0, 0}, '{79, 29}, '{40, 15}};
    rst = 1'b1; wr_valid = 1'b1; wr_col = 7'd0; wr_row = 5'd0; wr_char = 8'h20;
    clr_req = 1'b0; pix_x = 10'd0; pix_y = 10'd0; pix_active = 1'b0; font_data = 8'h00;
    tick();
    tick();
    n_checks += 5;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
    if (pix_on !== 1'b0) begin n_fail++; $display("FAIL reset_pix_on: got %b expected 0", pix_on); end
    if (pix_de !== 1'b0) begin n_fail++; $display("FAIL reset_pix_de: got %b expected 0", pix_de); end
    if (font_addr !== 12'h000) begin
      n_fail++; $display("FAIL reset_font_addr: got %h expected 000", font_addr);
    end
    rst = 1'b0;
    wait_ready(n);
    wr_valid = 1'b0;
    n_checks++;
    if (n !== 2400) begin n_fail++; $display("FAIL clear_len: got %0d expected 2400", n); end
    foreach (cells[i]) begin
      read_cell(cells[i][0], cells[i][1], code);
      n_checks++;
      if (code !== 8'h20) begin
        n_fail++; $display("FAIL init_cell_%0d: got %h expected 20", i, code);
      end
    end
  endtask

  task automatic test_write_read();
    logic [11:0] addr;
    logic        on, de;
    write_cell(2, 1, 8'h41);
    n_checks++;
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_inrange: got %b expected 0", wr_err); end
    probe(16, 21, 1'b1, 8'h80, addr, on, de);
    n_checks += 3;
    if (addr !== 12'h415) begin n_fail++; $display("FAIL font_addr: got %h expected 415", addr); end
    if (on !== 1'b1) begin n_fail++; $display("FAIL pix_on_msb: got %b expected 1", on); end
    if (de !== 1'b1) begin n_fail++; $display("FAIL pix_de_msb: got %b expected 1", de); end
    probe(17, 21, 1'b1, 8'h80, addr, on, de);
    n_checks += 2;
    if (on !== 1'b0) begin n_fail++; $display("FAIL pix_on_bit6: got %b expected 0", on); end
    if (de !== 1'b1) begin n_fail++; $display("FAIL pix_de_bit6: got %b expected 1", de); end
    probe(23, 21, 1'b1, 8'h01, addr, on, de);
    n_checks++;
    if (on !== 1'b1) begin n_fail++; $display("FAIL pix_on_lsb: got %b expected 1", on); end
    probe(16, 21, 1'b0, 8'hFF, addr, on, de);
    n_checks += 2;
    if (on !== 1'b0) begin n_fail++; $display("FAIL pix_on_inactive: got %b expected 0", on); end
    if (de !== 1'b0) begin n_fail++; $display("FAIL pix_de_inactive: got %b expected 0", de); end
  endtask

  task automatic test_wr_err();
    logic [7:0] code;
    wr_valid = 1'b1; wr_col = 7'd80; wr_row = 5'd0; wr_char = 8'h55;
    tick();
    n_checks += 2;
    if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wr_err_col: got %b expected 1", wr_err); end
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_err: got %b expected 1", wr_ready); end
    wr_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_pulse: got %b expected 0", wr_err); end
    write_cell(0, 30, 8'h66);
    n_checks++;
    if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wr_err_row: got %b expected 1", wr_err); end
    for (int c = 0; c < 80; c++) begin
      read_cell(c, 0, code);
      n_checks++;
      if (code !== 8'h20) begin n_fail++; $display("FAIL row0_col%0d: got %h expected 20", c, code); end
    end
    read_cell(0, 1, code);
    n_checks++;
    if (code !== 8'h20) begin n_fail++; $display("FAIL row1_col0: got %h expected 20", code); end
    read_cell(2, 1, code);
    n_checks++;
    if (code !== 8'h41) begin n_fail++; $display("FAIL row1_col2: got %h expected 41", code); end
    read_cell(0, 29, code);
    n_checks++;
    if (code !== 8'h20) begin n_fail++; $display("FAIL row29_col0: got %h expected 20", code); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] code;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_col  = 7'(10 + i);
      wr_row  = 5'd5;
      wr_char = 8'(8'h61 + i);
      n_checks++;
      if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, wr_ready); end
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_cell(10 + i, 5, code);
      n_checks++;
      if (code !== 8'(8'h61 + i)) begin
        n_fail++; $display("FAIL b2b_cell_%0d: got %h expected %h", i, code, 8'(8'h61 + i));
      end
    end
    wr_valid = 1'b1; wr_col = 7'd10; wr_row = 5'd5; wr_char = 8'h7A;
    pix_x = 10'd80; pix_y = 10'd80; pix_active = 1'b1;
    tick();
    code = font_addr[11:4];
    wr_valid = 1'b0; pix_active = 1'b0;
    n_checks++;
    if (code !== 8'h61) begin n_fail++; $display("FAIL rw_same_old: got %h expected 61", code); end
    read_cell(10, 5, code);
    n_checks++;
    if (code !== 8'h7A) begin n_fail++; $display("FAIL rw_same_new: got %h expected 7a", code); end
  endtask

  task automatic test_clear_reset();
    int         n;
    logic [7:0] code;
    int         cells [5][2] = '{'{3, 3}, '{2, 1}, '{10, 5}, '{79, 29}, '{0, 0}};
    wr_valid = 1'b1; wr_col = 7'd3; wr_row = 5'd3; wr_char = 8'h33; clr_req = 1'b1;
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_enter: got %b expected 0", wr_ready); end
    read_cell(3, 3, code);
    n_checks++;
    if (code !== 8'h33) begin n_fail++; $display("FAIL clr_same_cycle_write: got %h expected 33", code); end
    repeat (98) tick();
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b expected 0", wr_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    n_checks++;
    if (n !== 2400) begin n_fail++; $display("FAIL clr_restart_len: got %0d expected 2400", n); end
    foreach (cells[i]) begin
      read_cell(cells[i][0], cells[i][1], code);
      n_checks++;
      if (code !== 8'h20) begin n_fail++; $display("FAIL cleared_cell_%0d: got %h expected 20", i, code); end
    end
  endtask

`ifdef CURSOR_BLINK_EN
  task automatic test_cursor();
    int          n;
    logic [11:0] addr;
    logic        on, de;
    int          vec [7][4] = '{'{0, 14, 0, 1}, '{0, 15, 0, 1}, '{7, 14, 0, 1}, '{0, 13, 0, 0},
                                '{8, 14, 0, 0}, '{0, 30, 0, 0}, '{0, 14, 255, 0}};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    probe(0, 14, 1'b1, 8'h00, addr, on, de);
    n_checks++;
    if (on !== 1'b0) begin n_fail++; $display("FAIL cursor_phase0: got %b expected 0", on); end
    pix_x = 10'd0; pix_y = 10'd0; pix_active = 1'b1;
    repeat (16) tick();
    pix_active = 1'b0;
    foreach (vec[i]) begin
      probe(vec[i][0], vec[i][1], 1'b1, 8'(vec[i][2]), addr, on, de);
      n_checks++;
      if (on !== 1'(vec[i][3])) begin
        n_fail++; $display("FAIL cursor_vec_%0d: got %b expected %0d", i, on, vec[i][3]);
      end
    end
    pix_x = 10'd0; pix_y = 10'd0; pix_active = 1'b1;
    repeat (16) tick();
    pix_active = 1'b0;
    probe(0, 14, 1'b1, 8'h00, addr, on, de);
    n_checks++;
    if (on !== 1'b0) begin n_fail++; $display("FAIL cursor_revert: got %b expected 0", on); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_wr_err();
    test_back_to_back();
    test_clear_reset();
`ifdef CURSOR_BLINK_EN
    test_cursor();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
